// File: rtl/regfile_dumper.sv
// Sweeps a register file read port and streams each word out as a valid/ready beat.
// Define REGFILE_DUMP_CHECKSUM_EN to append an XOR-checksum beat (index 32).
module regfile_dumper #(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rf_rs,
    input  logic [31:0] rf_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_index,
    output logic [31:0] out_data
);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StAddr, StRead, StSend, StCsum, StDone} state_e;
`else
    typedef enum logic [2:0] {StIdle, StAddr, StRead, StSend, StDone} state_e;
`endif

    localparam logic [4:0] LastIdx = 5'(NUM_REGS - 1);

    state_e      state_q, state_d;
    logic [4:0]  k_q, k_d;
    logic        out_valid_q, out_valid_d;
    logic [5:0]  out_index_q, out_index_d;
    logic [31:0] out_data_q, out_data_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [31:0] acc_q, acc_d;
`endif

    // k only moves on the edge into ADDR, so rf_rs can follow it directly.
    assign rf_rs     = k_q;
    assign busy      = (state_q != StIdle) && (state_q != StDone);
    assign done      = (state_q == StDone);
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_data  = out_data_q;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        acc_d       = acc_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAddr;
                    k_d     = '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            StAddr: state_d = StRead;
            StRead: begin
                out_valid_d = 1'b1;
                out_index_d = {1'b0, k_q};
                out_data_d  = rf_data;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                acc_d       = acc_q ^ rf_data;
`endif
                state_d     = StSend;
            end
            StSend: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (k_q == LastIdx) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        // Checksum beat goes out back-to-back with the last register beat.
                        state_d     = StCsum;
                        out_valid_d = 1'b1;
                        out_index_d = 6'd32;
                        out_data_d  = acc_q;
`else
                        state_d     = StDone;
`endif
                    end else begin
                        k_d     = k_q + 5'd1;
                        state_d = StAddr;
                    end
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            StCsum: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StDone;
                end
            end
`endif
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_data_q  <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc_q       <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_dumper.sv
// Scoreboard bench for regfile_dumper: a reference model queues expected beats per dump,
// a negedge monitor pops and compares every accepted beat.
module tb_regfile_dumper;
    localparam int NumRegs = 32;
    localparam int Bound   = 3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  rf_rs;
    logic [31:0] rf_data;
    logic [5:0]  out_index;
    logic [31:0] out_data;

    logic [31:0] regs [32];
    logic [31:0] seen_data [33];
    logic [37:0] exp_q [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = -10;
    int done_cnt = 0;
    bit stall = 1'b0;
    logic [5:0]  st_idx;
    logic [31:0] st_data;

    regfile_dumper #(.NUM_REGS(NumRegs)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rf_rs(rf_rs), .rf_data(rf_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_data(out_data)
    );

    initial forever #5 clk = ~clk;

    // Register file read port: data follows the address sampled at the previous edge.
    always @(posedge clk) rf_data <= regs[rf_rs];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [37:0] e;
        cyc++;
        if (reset) begin
            stall = 1'b0;
        end else begin
            if (stall) chk("hold_stable", {out_valid, out_index, out_data}, {1'b1, st_idx, st_data});
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat actual=%0d/%h required=none", out_index, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_index, out_data} !== e) begin
                        errors++;
                        $display("FAIL beat actual=%0d/%h required=%0d/%h",
                                 out_index, out_data, e[37:32], e[31:0]);
                    end
                end
                if (out_index <= 6'd32) seen_data[out_index] = out_data;
                hs_cyc = cyc;
            end
            stall = out_valid && !out_ready;
            st_idx = out_index;
            st_data = out_data;
            if (done) begin
                done_cnt++;
                chk("done_after_last_hs", 32'(cyc), 32'(hs_cyc + 1));
            end
        end
    end

    task automatic init_regs();
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[1] = 32'd7;
        regs[2] = 32'd7;
        regs[29] = 32'd252;
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 33; i++) seen_data[i] = 32'hA5A5_5A5A;
    endtask

    task automatic push_expected();
        logic [31:0] x = '0;
        for (int i = 0; i < NumRegs; i++) begin
            exp_q.push_back({6'(i), regs[i]});
            x ^= regs[i];
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        exp_q.push_back({6'd32, x});
`endif
    endtask

    task automatic run_dump(input bit rnd, input int repulse, input int stall_at);
        int n = 1;
        int lat = -1;
        int stall_left = 0;
        int d0 = done_cnt;
        bit got = 1'b0;
        bit pulsed = 1'b0;
        bit stalled = 1'b0;
        push_expected();
        @(posedge clk); #1 start = 1'b1;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        while (n < Bound) begin
            if (out_valid && lat < 0) lat = n;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (repulse >= 0 && !pulsed && out_valid && out_index == 6'(repulse)) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall_at >= 0 && !stalled && out_valid && out_index == 6'(stall_at)) begin
                stalled = 1'b1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                chk("stall_index", 32'(out_index), 32'(stall_at));
                chk("stall_data", out_data, regs[stall_at]);
                out_ready = 1'b0;
                stall_left--;
            end
            @(posedge clk); #1 start = 1'b0;
            n++;
        end
        chk("done_reached", 32'(got), 32'd1);
        chk("first_beat_latency", 32'(lat), 32'd3);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("beats_left", 32'(exp_q.size()), 32'd0);
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("idle_after_done", 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    task automatic reset_mid_dump();
        int n = 0;
        int d0 = done_cnt;
        push_expected();
        out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (n < Bound && !(out_valid && out_index == 6'd10)) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_beat10", 32'(out_index), 32'd10);
        out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        repeat (5) @(posedge clk);
        #1;
        chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rst_stays_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        init_regs();
        clear_seen();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_index", 32'(out_index), 32'd0);
        chk("reset_data", out_data, 32'd0);
        chk("reset_rs", 32'(rf_rs), 32'd0);
        reset = 1'b0;

        run_dump(1'b0, -1, -1);
        chk("fresh_r0", seen_data[0], 32'd0);
        chk("fresh_r1", seen_data[1], 32'd7);
        chk("fresh_r2", seen_data[2], 32'd7);
        chk("fresh_r29", seen_data[29], 32'd252);
        chk("fresh_r31", seen_data[31], 32'd0);
`ifdef REGFILE_DUMP_CHECKSUM_EN
        chk("fresh_csum", seen_data[32], 32'h0000_00FC);
`else
        chk("no_csum_beat", seen_data[32], 32'hA5A5_5A5A);
`endif

        run_dump(1'b0, -1, 2);
        run_dump(1'b0, 10, -1);
        reset_mid_dump();
        run_dump(1'b0, -1, -1);

        clear_seen();
        regs[5] = 32'hDEAD_BEEF;
        run_dump(1'b0, -1, -1);
        chk("r5_word", seen_data[5], 32'hDEAD_BEEF);
`ifdef REGFILE_DUMP_CHECKSUM_EN
        chk("r5_csum", seen_data[32], 32'hDEAD_BE13);
`endif

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            run_dump(1'b1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
